// File: rtl/tcn_fifo_sequencer.sv
// Per-time-step sequencer for the TCN circular activation buffer: writes the newest block,
// streams a read of the whole window, then pulses the encoder pointer advance.
module tcn_fifo_sequencer #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] cfg_total_blocks,
    input  logic [31:0]       cfg_block_size,
    input  logic              cfg_tcn_active,
    input  logic              wr_ready,
    input  logic              rd_ready,
    output logic              wr_enable,
    output logic [ADDR_W-1:0] wr_address,
    output logic              rd_enable,
    output logic [ADDR_W-1:0] rd_address,
    output logic              update_pointer,
    output logic              busy,
    output logic              done,
    output logic              err_cfg,
    output logic [2:0]        state_dbg
);

    localparam int PW = ADDR_W + CNT_W;
    localparam logic [PW-1:0] WIN_MAX = PW'(1) << ADDR_W;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_WRITE  = 3'd2,
        S_READ   = 3'd3,
        S_UPDATE = 3'd4,
        S_SETTLE = 3'd5,
        S_DONE   = 3'd6
    } state_t;

    state_t state_q, state_n;

    logic [ADDR_W-1:0] n_q;
    logic [CNT_W-1:0]  rb_q;
    logic [CNT_W-1:0]  wb_q;
    logic              active_q;
    logic [CNT_W-1:0]  wr_cnt;
    logic [PW-1:0]     rd_cnt;
    logic              settle_q;

    logic [PW-1:0]     rd_total;
    logic [PW-1:0]     wr_total;
    logic [ADDR_W-1:0] wr_base;
    logic              cfg_bad;
    logic              wr_last;
    logic              rd_last;

    assign state_dbg = state_q;

    // Window products are kept at full width so an oversized config is caught, not wrapped.
    always_comb begin
        rd_total = PW'(n_q) * PW'(rb_q);
        wr_total = PW'(n_q) * PW'(wb_q);
        wr_base  = ADDR_W'(PW'(n_q - ADDR_W'(1)) * PW'(wb_q));
        cfg_bad  = (n_q == '0) || (rb_q == '0) || (wb_q == '0) ||
                   (rd_total > WIN_MAX) || (wr_total > WIN_MAX);
        wr_last  = (wr_cnt == wb_q - CNT_W'(1));
        rd_last  = (rd_cnt == rd_total - PW'(1));
    end

    // Handshake: a beat transfers on the cycle where enable and ready are both high;
    // while ready is low the enable and address are held unchanged.
    always_comb begin
        state_n = state_q;
        if (state_q != S_IDLE && abort) begin
            state_n = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE:   if (start && !abort) state_n = S_CHECK;
                S_CHECK:  state_n = cfg_bad ? S_DONE : S_WRITE;
                S_WRITE:  if (wr_ready && wr_last) state_n = S_READ;
                S_READ:   if (rd_ready && rd_last) state_n = active_q ? S_UPDATE : S_DONE;
                S_UPDATE: state_n = S_SETTLE;
                S_SETTLE: if (settle_q) state_n = S_DONE;
                S_DONE:   state_n = S_IDLE;
                default:  state_n = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            n_q            <= '0;
            rb_q           <= '0;
            wb_q           <= '0;
            active_q       <= 1'b0;
            wr_cnt         <= '0;
            rd_cnt         <= '0;
            settle_q       <= 1'b0;
            wr_enable      <= 1'b0;
            wr_address     <= '0;
            rd_enable      <= 1'b0;
            rd_address     <= '0;
            update_pointer <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_cfg        <= 1'b0;
        end else begin
            state_q        <= state_n;
            wr_enable      <= (state_n == S_WRITE);
            rd_enable      <= (state_n == S_READ);
            update_pointer <= (state_n == S_UPDATE);
            busy           <= (state_n != S_IDLE);
            done           <= (state_n == S_DONE);
            err_cfg        <= (state_q == S_CHECK) && (state_n == S_DONE);
            settle_q       <= (state_q == S_SETTLE) ? ~settle_q : 1'b0;

            if (state_q == S_IDLE && state_n == S_CHECK) begin
                n_q      <= cfg_total_blocks;
                rb_q     <= CNT_W'(cfg_block_size[15:0]);
                wb_q     <= CNT_W'(cfg_block_size[31:16]);
                active_q <= cfg_tcn_active;
            end

            // Newest block occupies the last slot of the logical window.
            if (state_q == S_CHECK) begin
                wr_cnt     <= '0;
                wr_address <= wr_base;
            end else if (state_q == S_WRITE && wr_ready) begin
                wr_cnt     <= wr_cnt + CNT_W'(1);
                wr_address <= wr_address + ADDR_W'(1);
            end

            if (state_q == S_CHECK) begin
                rd_cnt     <= '0;
                rd_address <= '0;
            end else if (state_q == S_READ && rd_ready) begin
                rd_cnt     <= rd_cnt + PW'(1);
                rd_address <= rd_address + ADDR_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tcn_fifo_sequencer.sv
// Scoreboard bench for tcn_fifo_sequencer: a window-level model queues the expected beat and
// pulse stream per step; a negedge monitor pops and compares whatever the DUT presents.
module tb_tcn_fifo_sequencer;

    localparam int ADDR_W = 8;
    localparam int CNT_W  = 16;
    localparam int W      = 2 + 1 + ADDR_W;
    localparam logic [1:0] EV_WR = 2'd0, EV_RD = 2'd1, EV_UPD = 2'd2, EV_DONE = 2'd3;

    logic              clk;
    logic              reset;
    logic              start;
    logic              abort;
    logic [ADDR_W-1:0] cfg_total_blocks;
    logic [31:0]       cfg_block_size;
    logic              cfg_tcn_active;
    logic              wr_ready;
    logic              rd_ready;
    logic              wr_enable;
    logic [ADDR_W-1:0] wr_address;
    logic              rd_enable;
    logic [ADDR_W-1:0] rd_address;
    logic              update_pointer;
    logic              busy;
    logic              done;
    logic              err_cfg;
    logic [2:0]        state_dbg;

    logic [W-1:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int upd_cnt = 0;
    int done_cnt = 0;
    int addr10_cnt = 0;
    int ready_mode = 0;
    int stall_cnt = 0;
    logic [ADDR_W-1:0] stall_addr = '0;

    tcn_fifo_sequencer #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_total_blocks(cfg_total_blocks), .cfg_block_size(cfg_block_size),
        .cfg_tcn_active(cfg_tcn_active), .wr_ready(wr_ready), .rd_ready(rd_ready),
        .wr_enable(wr_enable), .wr_address(wr_address), .rd_enable(rd_enable),
        .rd_address(rd_address), .update_pointer(update_pointer), .busy(busy),
        .done(done), .err_cfg(err_cfg), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] ev(input logic [1:0] t, input logic e, input logic [ADDR_W-1:0] a);
        return {t, e, a};
    endfunction

    task automatic check_val(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic expect_ev(input string name, input logic [W-1:0] got, input bit pop);
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s unexpected event got %h", name, got);
        end else begin
            if (exp_q[0] !== got) begin
                errors++;
                $display("FAIL %s got %h expected %h", name, got, exp_q[0]);
            end
            if (pop) void'(exp_q.pop_front());
        end
    endtask

    // Reference model: one step's observable stream from the window arithmetic.
    task automatic push_model(input int n, input int rb, input int wb, input bit act);
        if (n == 0 || rb == 0 || wb == 0 || n * rb > 256 || n * wb > 256) begin
            exp_q.push_back(ev(EV_DONE, 1'b1, '0));
        end else begin
            for (int i = 0; i < wb; i++) exp_q.push_back(ev(EV_WR, 1'b0, ADDR_W'((n - 1) * wb + i)));
            for (int j = 0; j < n * rb; j++) exp_q.push_back(ev(EV_RD, 1'b0, ADDR_W'(j)));
            if (act) exp_q.push_back(ev(EV_UPD, 1'b0, '0));
            exp_q.push_back(ev(EV_DONE, 1'b0, '0));
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (wr_enable && wr_address == 8'd10) addr10_cnt++;
        if (update_pointer) upd_cnt++;
        if (done) done_cnt++;
        if (wr_enable || rd_enable || update_pointer)
            check_val("enable_exclusive", int'(wr_enable) + int'(rd_enable) + int'(update_pointer), 1);
        if (wr_enable) expect_ev("wr_beat", ev(EV_WR, 1'b0, wr_address), wr_ready);
        if (rd_enable) expect_ev("rd_beat", ev(EV_RD, 1'b0, rd_address), rd_ready);
        if (update_pointer) expect_ev("update_pointer", ev(EV_UPD, 1'b0, '0), 1'b1);
        if (done) expect_ev("done", ev(EV_DONE, err_cfg, '0), 1'b1);
        if (err_cfg && !done) check_val("err_without_done", 1, 0);
    end

    // Ready driver
    initial begin
        wr_ready = 1'b1;
        rd_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    wr_ready = ($urandom_range(0, 3) != 0);
                    rd_ready = ($urandom_range(0, 3) != 0);
                end
                2: begin
                    rd_ready = 1'b1;
                    if (wr_enable && wr_address == stall_addr && stall_cnt < 3) begin
                        wr_ready = 1'b0;
                        stall_cnt++;
                    end else begin
                        wr_ready = 1'b1;
                    end
                end
                default: begin
                    wr_ready = 1'b1;
                    rd_ready = 1'b1;
                end
            endcase
        end
    end

    task automatic set_cfg(input int n, input int rb, input int wb, input bit act);
        cfg_total_blocks = ADDR_W'(n);
        cfg_block_size   = {16'(wb), 16'(rb)};
        cfg_tcn_active   = act;
    endtask

    // cycles = posedges from the one that samples start to the one after which done is high
    task automatic run_step(input int n, input int rb, input int wb, input bit act,
                            input bit chaos, output int cycles);
        push_model(n, rb, wb, act);
        @(negedge clk);
        set_cfg(n, rb, wb, act);
        start = 1'b1;
        @(posedge clk);
        cycles = 1;
        @(negedge clk);
        start = 1'b0;
        while (!done && cycles < 4000) begin
            if (chaos) begin
                set_cfg($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 20), 1'($urandom_range(0, 1)));
                start = busy && ($urandom_range(0, 5) == 0);
            end
            @(posedge clk);
            cycles++;
            @(negedge clk);
        end
        start = 1'b0;
        if (!done) begin
            check_val("step_timeout", cycles, -1);
            exp_q.delete();
        end
        @(posedge clk);
        #1;
        check_val("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_wr_enable"}, int'(wr_enable), 0);
        check_val({tag, "_rd_enable"}, int'(rd_enable), 0);
        check_val({tag, "_update_pointer"}, int'(update_pointer), 0);
        check_val({tag, "_busy"}, int'(busy), 0);
        check_val({tag, "_done"}, int'(done), 0);
        check_val({tag, "_err_cfg"}, int'(err_cfg), 0);
        check_val({tag, "_wr_address"}, int'(wr_address), 0);
        check_val({tag, "_rd_address"}, int'(rd_address), 0);
    endtask

    initial begin
        int cyc;
        int u0;
        int d0;
        int a0;
        int k;
        reset = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        set_cfg(4, 3, 3, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        reset = 1'b1;

        // Basic step, then the same with cfg churn and stray starts while busy
        u0 = upd_cnt;
        run_step(4, 3, 3, 1'b1, 1'b0, cyc);
        check_val("t1_done_cycle", cyc, 20);
        check_val("t1_update_count", upd_cnt - u0, 1);
        run_step(4, 3, 3, 1'b1, 1'b1, cyc);
        check_val("t1_shadow_done_cycle", cyc, 20);

        // Write stall on beat 1
        ready_mode = 2;
        stall_addr = 8'd10;
        stall_cnt  = 0;
        a0 = addr10_cnt;
        run_step(4, 3, 3, 1'b1, 1'b0, cyc);
        check_val("stall_addr10_cycles", addr10_cnt - a0, 4);
        check_val("stall_done_cycle", cyc, 23);
        ready_mode = 0;

        // Plain buffer mode
        u0 = upd_cnt;
        d0 = done_cnt;
        run_step(2, 4, 4, 1'b0, 1'b0, cyc);
        check_val("plain_update_count", upd_cnt - u0, 0);
        check_val("plain_done_count", done_cnt - d0, 1);
        check_val("plain_done_cycle", cyc, 14);

        // Illegal configs and window-size boundaries
        run_step(0, 3, 3, 1'b1, 1'b0, cyc);
        check_val("n0_done_cycle", cyc, 2);
        run_step(3, 0, 2, 1'b1, 1'b0, cyc);
        run_step(3, 2, 0, 1'b1, 1'b0, cyc);
        run_step(16, 16, 2, 1'b1, 1'b0, cyc);
        check_val("full_window_done_cycle", cyc, 2 + 2 + 256 + 1 + 2);
        run_step(17, 16, 1, 1'b1, 1'b0, cyc);
        check_val("n17_done_cycle", cyc, 2);
        run_step(2, 1, 200, 1'b1, 1'b0, cyc);
        run_step(1, 1, 256, 1'b0, 1'b0, cyc);

        // Abort mid-READ at j=5
        push_model(4, 3, 3, 1'b1);
        @(negedge clk);
        set_cfg(4, 3, 3, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(rd_enable && rd_address == 8'd5) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_val("abort_reached_j5", int'(rd_enable && rd_address == 8'd5), 1);
        u0 = upd_cnt;
        d0 = done_cnt;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        exp_q.delete();
        check_val("abort_busy", int'(busy), 0);
        check_val("abort_rd_enable", int'(rd_enable), 0);
        check_val("abort_state", int'(state_dbg), 0);
        repeat (5) @(negedge clk);
        check_val("abort_no_update", upd_cnt - u0, 0);
        check_val("abort_no_done", done_cnt - d0, 0);
        run_step(4, 3, 3, 1'b1, 1'b0, cyc);
        check_val("after_abort_done_cycle", cyc, 20);

        // Reset mid-WRITE
        push_model(2, 2, 8, 1'b1);
        @(negedge clk);
        set_cfg(2, 2, 8, 1'b1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (!(wr_enable && wr_address == 8'd10) && k < 200) begin
            @(negedge clk);
            k++;
        end
        check_val("reset_reached_beat2", int'(wr_enable && wr_address == 8'd10), 1);
        reset = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check_outputs_zero("midreset");
        @(negedge clk);
        reset = 1'b1;
        run_step(2, 2, 8, 1'b1, 1'b0, cyc);
        check_val("after_reset_done_cycle", cyc, 17);

        // Randomized steps with random backpressure
        ready_mode = 1;
        for (int t = 0; t < 40; t++) begin
            run_step($urandom_range(0, 10), $urandom_range(0, 8), $urandom_range(0, 8),
                     1'($urandom_range(0, 1)), 1'b1, cyc);
        end
        ready_mode = 0;
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
